// File: rtl/csr_timer_pkg.sv
// csr_timer_pkg: CSR addresses and TCFG field positions shared by the timer CSR unit.
package csr_timer_pkg;
    localparam logic [13:0] CSR_TCFG  = 14'h41;
    localparam logic [13:0] CSR_TVAL  = 14'h42;
    localparam logic [13:0] CSR_TICLR = 14'h44;
    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;
endpackage

// File: rtl/csr_timer_dff.sv
// csr_timer_dff: standard 1-bit flop with asynchronous active-high reset to 0.
module csr_timer_dff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= 1'b0;
        else q <= d;
endmodule

// File: rtl/csr_timer.sv
// csr_timer: constant-frequency countdown timer owning TCFG/TVAL/TICLR and the level timer interrupt.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter int TIMER_WIDTH = 32,
    parameter int CSR_AW      = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csr_wr_en,
    input  logic [CSR_AW-1:0] csr_wr_addr,
    input  logic [31:0]       csr_wr_data,
    input  logic [CSR_AW-1:0] csr_rd_addr,
    output logic [31:0]       csr_rd_data,
    output logic              csr_rd_hit,
    output logic              csr_timer_intr_sync
);
    logic [TIMER_WIDTH-1:0] tcfg_q, tval_q, tval_d, load_val, wr_load;
    logic armed_q, armed_d, pend_q, pend_d;
    logic tcfg_wr, ticlr_wr, counting, expire, periodic;

    always_comb begin
        tcfg_wr  = csr_wr_en && csr_wr_addr == CSR_TCFG;
        ticlr_wr = csr_wr_en && csr_wr_addr == CSR_TICLR && csr_wr_data[0];
        periodic = tcfg_q[TCFG_PERIODIC];
        load_val = {tcfg_q[TIMER_WIDTH-1:TCFG_INITVAL_LSB], 2'b00};
        wr_load  = {csr_wr_data[TIMER_WIDTH-1:TCFG_INITVAL_LSB], 2'b00};
        // A TCFG write suppresses counting, so it also pre-empts an expire on the same edge.
        counting = tcfg_q[TCFG_EN] && armed_q && !tcfg_wr;
        expire   = counting && tval_q == '0;
        tval_d   = (tcfg_wr && csr_wr_data[TCFG_EN]) ? wr_load :
                   !counting ? tval_q :
                   !expire ? tval_q - TIMER_WIDTH'(1) :
                   periodic ? load_val : tval_q;
        armed_d  = tcfg_wr ? csr_wr_data[TCFG_EN] : (expire && !periodic) ? 1'b0 : armed_q;
        pend_d   = expire ? 1'b1 : ticlr_wr ? 1'b0 : pend_q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tcfg_q  <= '0;
            tval_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            if (tcfg_wr) tcfg_q <= csr_wr_data[TIMER_WIDTH-1:0];
            tval_q  <= tval_d;
            armed_q <= armed_d;
        end

    csr_timer_dff u_pend (.clk(clk), .reset(reset), .d(pend_d), .q(pend_q));

    assign csr_timer_intr_sync = pend_q;

    always_comb begin
        csr_rd_hit  = csr_rd_addr == CSR_TCFG || csr_rd_addr == CSR_TVAL || csr_rd_addr == CSR_TICLR;
        csr_rd_data = csr_rd_addr == CSR_TCFG ? 32'(tcfg_q) :
                      csr_rd_addr == CSR_TVAL ? 32'(tval_q) : 32'd0;
    end
endmodule
